// File: rtl/jesd204_rx_block_sync_64b_pkg.sv
// jesd204_rx_block_sync_64b_pkg: shared state encodings, sync-header codes and default parameters
// for the 64b/66b sync-header lock detector.
package jesd204_rx_block_sync_64b_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'b00,
      ST_SLIP   = 2'b01,
      ST_LOCKED = 2'b10
   } state_t;

   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   localparam int DEF_LOCK_COUNT = 64;
   localparam int DEF_BAD_WINDOW = 64;
   localparam int DEF_BAD_MAX    = 16;
   localparam int DEF_SLIP_WAIT  = 32;

   function automatic logic sh_ok(input logic [1:0] h);
      return (h == SH_DATA) || (h == SH_CTRL);
   endfunction

endpackage

// File: rtl/jesd204_rx_sh_err_monitor.sv
// jesd204_rx_sh_err_monitor: windowed invalid-header counter used while locked;
// flags loss of lock on the BAD_MAX-th bad header inside one BAD_WINDOW-header window.
module jesd204_rx_sh_err_monitor
   import jesd204_rx_block_sync_64b_pkg::*;
#(
   parameter int BAD_WINDOW = DEF_BAD_WINDOW,
   parameter int BAD_MAX    = DEF_BAD_MAX
) (
   input  logic i_clk,
   input  logic i_resetn,
   input  logic i_clear,
   input  logic i_hdr_valid,
   input  logic i_hdr_bad,
   output logic o_lose_lock
);

   localparam int WW = $clog2(BAD_WINDOW);
   localparam int BW = WW + 1;

   logic [WW-1:0] r_win;
   logic [BW-1:0] r_bad;
   logic          w_wrap;

   assign w_wrap      = r_win == WW'(BAD_WINDOW - 1);
   // Loss of lock takes priority over the window wrap clearing bad_cnt.
   assign o_lose_lock = i_hdr_valid && i_hdr_bad && (r_bad == BW'(BAD_MAX - 1));

   always_ff @(posedge i_clk or negedge i_resetn)
      if (!i_resetn) begin
         r_win <= '0;
         r_bad <= '0;
      end else if (i_clear || o_lose_lock) begin
         r_win <= '0;
         r_bad <= '0;
      end else if (i_hdr_valid) begin
         r_win <= r_win + WW'(1);
         r_bad <= w_wrap ? '0 : r_bad + BW'(i_hdr_bad);
      end

endmodule

// File: rtl/jesd204_rx_block_sync_64b.sv
// jesd204_rx_block_sync_64b: per-lane 64b/66b sync-header lock FSM with bitslip requests.
// Optional JESD204_RX_BLOCK_SYNC_ERR_CNT_EN adds a clearable saturating locked-state error counter.
module jesd204_rx_block_sync_64b
   import jesd204_rx_block_sync_64b_pkg::*;
#(
   parameter int LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int BAD_WINDOW = DEF_BAD_WINDOW,
   parameter int BAD_MAX    = DEF_BAD_MAX,
   parameter int SLIP_WAIT  = DEF_SLIP_WAIT
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic        i_cfg_disable,
   input  logic [1:0]  i_phy_header,
   input  logic        i_phy_header_valid,
`ifdef JESD204_RX_BLOCK_SYNC_ERR_CNT_EN
   input  logic        i_err_count_clear,
   output logic [31:0] o_status_err_count,
`endif
   output logic        o_phy_bitslip,
   output logic        o_phy_block_sync,
   output logic [1:0]  o_status_state,
   output logic [7:0]  o_status_slip_count
);

   localparam int GW = $clog2(LOCK_COUNT);

   state_t        r_state, w_next;
   logic [GW-1:0] r_good, w_good_nx;
   logic [7:0]    r_wait, w_wait_nx;
   logic [7:0]    r_slip_cnt;
   logic          r_bitslip, r_sync;
   logic          w_ok, w_lock_eval, w_lose_lock, w_slip_entry, w_lock_entry;

   assign w_ok         = sh_ok(i_phy_header);
   assign w_lock_eval  = (r_state == ST_LOCKED) && i_phy_header_valid && !i_cfg_disable;
   assign w_slip_entry = (w_next == ST_SLIP) && (r_state != ST_SLIP);
   assign w_lock_entry = (w_next == ST_LOCKED) && (r_state != ST_LOCKED);

   jesd204_rx_sh_err_monitor #(
      .BAD_WINDOW(BAD_WINDOW),
      .BAD_MAX   (BAD_MAX)
   ) u_err_mon (
      .i_clk      (i_clk),
      .i_resetn   (i_resetn),
      .i_clear    ((r_state != ST_LOCKED) || i_cfg_disable),
      .i_hdr_valid(w_lock_eval),
      .i_hdr_bad  (!w_ok),
      .o_lose_lock(w_lose_lock)
   );

   always_comb begin
      w_next    = r_state;
      w_good_nx = r_good;
      w_wait_nx = r_wait;
      if (i_cfg_disable) begin
         w_next    = ST_HUNT;
         w_good_nx = '0;
         w_wait_nx = '0;
      end else begin
         case (r_state)
            ST_SLIP:
               if (r_wait == 8'(SLIP_WAIT)) begin
                  w_next    = ST_HUNT;
                  w_good_nx = '0;
                  w_wait_nx = '0;
               end else begin
                  w_wait_nx = r_wait + 8'd1;
               end
            ST_LOCKED:
               if (w_lose_lock) begin
                  w_next    = ST_HUNT;
                  w_good_nx = '0;
               end
            // HUNT and the unused 2'b11 encoding both behave as HUNT
            default: begin
               w_next = ST_HUNT;
               if (i_phy_header_valid) begin
                  if (!w_ok) begin
                     w_next    = ST_SLIP;
                     w_good_nx = '0;
                     w_wait_nx = '0;
                  end else if (r_good == GW'(LOCK_COUNT - 1)) begin
                     w_next    = ST_LOCKED;
                     w_good_nx = '0;
                  end else begin
                     w_good_nx = r_good + GW'(1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn)
      if (!i_resetn) begin
         r_state    <= ST_HUNT;
         r_good     <= '0;
         r_wait     <= '0;
         r_bitslip  <= 1'b0;
         r_sync     <= 1'b0;
         r_slip_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_good     <= w_good_nx;
         r_wait     <= w_wait_nx;
         r_bitslip  <= w_slip_entry;
         r_sync     <= w_next == ST_LOCKED;
         r_slip_cnt <= w_lock_entry ? '0 :
                       (w_slip_entry && r_slip_cnt != 8'hFF) ? r_slip_cnt + 8'd1 : r_slip_cnt;
      end

   assign o_phy_bitslip       = r_bitslip;
   assign o_phy_block_sync    = r_sync;
   assign o_status_state      = r_state;
   assign o_status_slip_count = r_slip_cnt;

`ifdef JESD204_RX_BLOCK_SYNC_ERR_CNT_EN
   logic [31:0] r_err_cnt;

   always_ff @(posedge i_clk or negedge i_resetn)
      if (!i_resetn)
         r_err_cnt <= '0;
      else if (i_err_count_clear)
         r_err_cnt <= '0;
      else if (w_lock_eval && !w_ok && r_err_cnt != 32'hFFFF_FFFF)
         r_err_cnt <= r_err_cnt + 32'd1;

   assign o_status_err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_jesd204_rx_block_sync_64b.sv
// tb_jesd204_rx_block_sync_64b: randomized self-checking bench against a counting reference model.
// Exercises the JESD204_RX_BLOCK_SYNC_ERR_CNT_EN counter too when that macro is defined.
module tb_jesd204_rx_block_sync_64b;

   localparam int LOCK = 64;
   localparam int WIN  = 64;
   localparam int BMAX = 16;
   localparam int SW   = 32;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        dis = 1'b0;
   logic        hv = 1'b0;
   logic [1:0]  hdr = 2'b00;
   logic        clr = 1'b0;
   logic        bitslip, sync;
   logic [1:0]  state;
   logic [7:0]  slip_cnt;
   logic [31:0] err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: mode 0=hunt 1=slip 2=locked, counts kept as plain integers
   int          m_mode, m_good, m_wait, m_slips, m_win, m_bad;
   longint      m_err;
   bit          m_slip;

   always #5 clk = ~clk;

   jesd204_rx_block_sync_64b dut (
      .i_clk              (clk),
      .i_resetn           (resetn),
      .i_cfg_disable      (dis),
      .i_phy_header       (hdr),
      .i_phy_header_valid (hv),
`ifdef JESD204_RX_BLOCK_SYNC_ERR_CNT_EN
      .i_err_count_clear  (clr),
      .o_status_err_count (err_cnt),
`endif
      .o_phy_bitslip      (bitslip),
      .o_phy_block_sync   (sync),
      .o_status_state     (state),
      .o_status_slip_count(slip_cnt)
   );

`ifndef JESD204_RX_BLOCK_SYNC_ERR_CNT_EN
   assign err_cnt = 32'd0;
`endif

   function automatic logic [11:0] exp_vec();
      return {2'(m_mode), m_mode == 2, m_slip, 8'(m_slips)};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_good = 0; m_wait = 0; m_slips = 0;
      m_win = 0; m_bad = 0; m_err = 0; m_slip = 0;
   endtask

   task automatic model_step(bit v, logic [1:0] h, bit d, bit c);
      bit bad;
      bad = !(h == 2'b01 || h == 2'b10);
      m_slip = 0;
      if (c) m_err = 0;
      else if (!d && m_mode == 2 && v && bad && m_err < 64'hFFFF_FFFF) m_err++;
      if (d) begin
         m_mode = 0; m_good = 0; m_wait = 0; m_win = 0; m_bad = 0;
      end else if (m_mode == 1) begin
         if (m_wait == SW) begin m_mode = 0; m_good = 0; end
         else m_wait++;
      end else if (m_mode == 2) begin
         if (v) begin
            m_win++;
            if (bad) m_bad++;
            if (m_bad == BMAX) begin m_mode = 0; m_win = 0; m_bad = 0; m_good = 0; end
            else if (m_win == WIN) begin m_win = 0; m_bad = 0; end
         end
      end else if (v) begin
         if (!bad) begin
            m_good++;
            if (m_good == LOCK) begin m_mode = 2; m_good = 0; m_slips = 0; m_win = 0; m_bad = 0; end
         end else begin
            m_mode = 1; m_wait = 0; m_good = 0; m_slip = 1;
            if (m_slips < 255) m_slips++;
         end
      end
   endtask

   task automatic tick(bit v, logic [1:0] h, bit d = 0, bit c = 0);
      hv = v; hdr = h; dis = d; clr = c;
      @(posedge clk);
      model_step(v, h, d, c);
      #1;
   endtask

   // one valid header, optionally preceded by a few unqualified cycles
   task automatic send(bit bad, bit gaps = 1);
      if (gaps) repeat ($urandom_range(0, 2)) tick(0, 2'($urandom));
      if (bad) tick(1, ($urandom % 2) ? 2'b00 : 2'b11);
      else tick(1, ($urandom % 2) ? 2'b01 : 2'b10);
   endtask

   task automatic apply_reset();
      resetn = 1'b0; hv = 0; dis = 0; clr = 0;
      model_reset();
      @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic lock_up();
      repeat (LOCK) send(0);
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({state, sync, bitslip, slip_cnt} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_state: got st=%0d sync=%0b slip=%0b cnt=%0d want all 0", state, sync, bitslip, slip_cnt);
      end
      n_checks++;
      if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
      apply_reset();
   endtask

   task automatic test_lock();
      bit seen_slip = 0;
      apply_reset();
      for (int i = 0; i < LOCK; i++) begin
         send(0);
         if (bitslip) seen_slip = 1;
         n_checks++;
         if (sync !== (i == LOCK - 1)) begin
            n_fail++; $display("FAIL lock_rise hdr%0d: got sync=%0b want %0b", i, sync, i == LOCK - 1);
         end
      end
      n_checks++;
      if (state !== 2'b10 || seen_slip) begin
         n_fail++; $display("FAIL lock_state: got st=%0d slip_seen=%0b want st=2 slip_seen=0", state, seen_slip);
      end
   endtask

   task automatic test_slip();
      apply_reset();
      repeat (9) send(0);
      tick(1, 2'b11);
      n_checks++;
      if ({state, bitslip, slip_cnt} !== {2'b01, 1'b1, 8'd1} || exp_vec() !== {state, sync, bitslip, slip_cnt}) begin
         n_fail++; $display("FAIL slip_entry: got st=%0d slip=%0b cnt=%0d want st=1 slip=1 cnt=1", state, bitslip, slip_cnt);
      end
      for (int k = 1; k <= SW + 1; k++) begin
         tick($urandom % 2, 2'($urandom));
         n_checks++;
         if ({state, sync, bitslip, slip_cnt} !== exp_vec() || state !== ((k <= SW) ? 2'b01 : 2'b00)) begin
            n_fail++; $display("FAIL slip_wait k=%0d: got st=%0d slip=%0b want st=%0d slip=0", k, state, bitslip, (k <= SW) ? 1 : 0);
         end
      end
      lock_up();
      n_checks++;
      if ({sync, slip_cnt} !== {1'b1, 8'd0}) begin
         n_fail++; $display("FAIL relock_after_slip: got sync=%0b cnt=%0d want sync=1 cnt=0", sync, slip_cnt);
      end
   endtask

   task automatic test_loss();
      apply_reset();
      lock_up();
      repeat (BMAX - 1) send(1);
      repeat (WIN - BMAX + 1) send(0);
      n_checks++;
      if (sync !== 1'b1) begin n_fail++; $display("FAIL win1_held: got sync=%0b want 1", sync); end
      repeat (BMAX - 1) send(1);
      n_checks++;
      if (sync !== 1'b1) begin n_fail++; $display("FAIL win2_held: got sync=%0b want 1", sync); end
      send(1);
      n_checks++;
      if ({state, sync, bitslip} !== {2'b00, 1'b0, 1'b0} || exp_vec() !== {state, sync, bitslip, slip_cnt}) begin
         n_fail++; $display("FAIL lose_lock: got st=%0d sync=%0b slip=%0b want st=0 sync=0 slip=0", state, sync, bitslip);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      lock_up();
      repeat (WIN - BMAX) send(0);
      repeat (BMAX - 1) send(1);
      send(0);
      send(1);
      n_checks++;
      if (sync !== 1'b1) begin n_fail++; $display("FAIL wrap_clears: got sync=%0b want 1", sync); end
      apply_reset();
      lock_up();
      repeat (WIN - BMAX) send(0);
      repeat (BMAX - 1) send(1);
      n_checks++;
      if (sync !== 1'b1) begin n_fail++; $display("FAIL pre_wrap: got sync=%0b want 1", sync); end
      send(1);
      n_checks++;
      if ({state, sync, bitslip} !== 4'b0000) begin
         n_fail++; $display("FAIL wrap_loss: got st=%0d sync=%0b slip=%0b want st=0 sync=0 slip=0", state, sync, bitslip);
      end
   endtask

   task automatic test_reset_mid_slip();
      apply_reset();
      repeat (3) send(0);
      tick(1, 2'b00);
      repeat (12) tick(1, 2'($urandom));
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if ({state, sync, bitslip, slip_cnt} !== 12'h000) begin
         n_fail++; $display("FAIL async_reset: got st=%0d sync=%0b slip=%0b cnt=%0d want all 0", state, sync, bitslip, slip_cnt);
      end
      model_reset();
      @(posedge clk);
      #1 resetn = 1'b1;
      lock_up();
      n_checks++;
      if ({state, sync, slip_cnt} !== {2'b10, 1'b1, 8'd0}) begin
         n_fail++; $display("FAIL post_reset_lock: got st=%0d sync=%0b cnt=%0d want st=2 sync=1 cnt=0", state, sync, slip_cnt);
      end
   endtask

   task automatic test_disable();
      apply_reset();
      lock_up();
      tick(1, 2'b01, 1);
      n_checks++;
      if ({state, sync} !== 3'b000) begin n_fail++; $display("FAIL dis_locked: got st=%0d sync=%0b want 0 0", state, sync); end
      repeat (5) tick(1, 2'b11, 1);
      n_checks++;
      if ({state, bitslip, slip_cnt} !== 11'd0) begin
         n_fail++; $display("FAIL dis_hunt: got st=%0d slip=%0b cnt=%0d want 0 0 0", state, bitslip, slip_cnt);
      end
      tick(1, 2'b11);
      tick(1, 2'b01, 1);
      n_checks++;
      if ({state, bitslip, slip_cnt} !== {2'b00, 1'b0, 8'd1} || exp_vec() !== {state, sync, bitslip, slip_cnt}) begin
         n_fail++; $display("FAIL dis_slip: got st=%0d slip=%0b cnt=%0d want st=0 slip=0 cnt=1", state, bitslip, slip_cnt);
      end
   endtask

   task automatic test_slip_saturate();
      apply_reset();
      repeat (260) begin
         tick(1, 2'b11);
         repeat (SW + 1) tick(0, 2'b00);
      end
      n_checks++;
      if (slip_cnt !== 8'd255 || m_slips != 255) begin
         n_fail++; $display("FAIL slip_saturate: got cnt=%0d want 255", slip_cnt);
      end
   endtask

   task automatic test_random();
      int bad_pct;
      apply_reset();
      for (int i = 0; i < 4000; i++) begin
         if (i % 500 == 0) bad_pct = (i / 500 % 4 == 0) ? 0 : (i / 500 % 4 == 1) ? 2 : (i / 500 % 4 == 2) ? 10 : 40;
         if ($urandom_range(0, 99) < bad_pct) tick($urandom_range(0, 9) < 8, ($urandom % 2) ? 2'b00 : 2'b11, $urandom_range(0, 199) == 0);
         else tick($urandom_range(0, 9) < 8, ($urandom % 2) ? 2'b01 : 2'b10, $urandom_range(0, 199) == 0);
         n_checks++;
         if ({state, sync, bitslip, slip_cnt} !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cyc%0d: got st=%0d sync=%0b slip=%0b cnt=%0d want st=%0d sync=%0b slip=%0b cnt=%0d",
                     i, state, sync, bitslip, slip_cnt, m_mode, m_mode == 2, m_slip, m_slips);
         end
`ifdef JESD204_RX_BLOCK_SYNC_ERR_CNT_EN
         n_checks++;
         if (err_cnt !== 32'(m_err)) begin n_fail++; $display("FAIL random_err cyc%0d: got %0d want %0d", i, err_cnt, m_err); end
`endif
      end
   endtask

`ifdef JESD204_RX_BLOCK_SYNC_ERR_CNT_EN
   task automatic test_err_count();
      apply_reset();
      lock_up();
      repeat (10) send(1);
      repeat (WIN - 10) send(0);
      repeat (10) send(1);
      n_checks++;
      if (err_cnt !== 32'd20 || m_err != 20 || sync !== 1'b1) begin
         n_fail++; $display("FAIL err_count: got %0d sync=%0b want 20 sync=1", err_cnt, sync);
      end
      tick(1, 2'b11, 0, 1);
      n_checks++;
      if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL err_clear: got %0d want 0", err_cnt); end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_lock();
      test_slip();
      test_loss();
      test_wrap();
      test_reset_mid_slip();
      test_disable();
      test_slip_saturate();
      test_random();
`ifdef JESD204_RX_BLOCK_SYNC_ERR_CNT_EN
      test_err_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
